// File: rtl/f11_wbi_irq.sv
// F-11 interrupt Wishbone responder: drives vm_virq priority levels, answers
// IACK cycles with the winning source's vector and fast-input cycles with vm_fdin.
module f11_wbi_irq #(
  parameter logic [15:0]  IRQ_LVL  = 16'h0000,
  parameter logic [127:0] IRQ_VEC  = 128'h0,
  parameter int           IRQ_WAIT = 0
) (
  input  logic        vm_clk_p,
  input  logic        vm_init,
  input  logic [7:0]  irq_req,
  output logic [7:0]  irq_ack,
  input  logic [15:0] vm_fdin,
  output logic [7:4]  vm_virq,
  input  logic        wbi_stb_i,
  input  logic        wbi_una_i,
  output logic        wbi_ack_o,
  output logic [15:0] wbi_dat_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [3:0] WAIT_INIT = 4'(IRQ_WAIT);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] data;
  logic [2:0]  sel;
  logic        una_q;

  logic       win_any;
  logic [2:0] win_idx;
  logic [1:0] win_lvl;
  logic [3:0] lvl_req;

  // Scan upward with strict '>' so the lowest index keeps ties.
  always_comb begin
    win_any = 1'b0;
    win_idx = 3'd0;
    win_lvl = 2'd0;
    for (int i = 0; i < 8; i++) begin
      if (irq_req[i] && (!win_any || IRQ_LVL[2*i +: 2] > win_lvl)) begin
        win_any = 1'b1;
        win_idx = 3'(i);
        win_lvl = IRQ_LVL[2*i +: 2];
      end
    end
  end

  always_comb begin
    lvl_req = 4'b0000;
    for (int i = 0; i < 8; i++)
      if (irq_req[i]) lvl_req[IRQ_LVL[2*i +: 2]] = 1'b1;
  end

  always_ff @(posedge vm_clk_p) begin
    if (vm_init) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      data      <= 16'h0000;
      sel       <= 3'd0;
      una_q     <= 1'b0;
      wbi_ack_o <= 1'b0;
      wbi_dat_o <= 16'h0000;
      irq_ack   <= 8'h00;
      vm_virq   <= 4'b0000;
    end else begin
      vm_virq   <= lvl_req;
      wbi_ack_o <= 1'b0;
      wbi_dat_o <= 16'h0000;
      irq_ack   <= 8'h00;
      case (state)
        S_IDLE: begin
          if (wbi_stb_i) begin
            cnt <= WAIT_INIT;
            if (wbi_una_i) begin
              data  <= vm_fdin;
              una_q <= 1'b1;
              state <= (WAIT_INIT == 4'd0) ? S_ACK : S_WAIT;
            end else if (win_any) begin
              data  <= IRQ_VEC[{win_idx, 4'h0} +: 16];
              sel   <= win_idx;
              una_q <= 1'b0;
              state <= (WAIT_INIT == 4'd0) ? S_ACK : S_WAIT;
            end else begin
              // Empty IACK: never acked, the CPU bus timer ends the cycle.
              state <= S_HOLD;
            end
          end
        end
        S_WAIT: begin
          if (!wbi_stb_i) begin
            state <= S_IDLE;
          end else if (cnt <= 4'd1) begin
            cnt   <= 4'd0;
            state <= S_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          if (!wbi_stb_i) begin
            state <= S_IDLE;
          end else begin
            wbi_ack_o <= 1'b1;
            wbi_dat_o <= data;
            if (!una_q) irq_ack <= 8'h01 << sel;
            state <= S_HOLD;
          end
        end
        default: begin
          if (!wbi_stb_i) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f11_wbi_irq.sv
// Randomized bench for f11_wbi_irq with a transaction-level expectation model
// and a per-cycle compare process.
module tb_f11_wbi_irq;

  localparam int W = 3;

  logic        clk = 1'b0;
  logic        vm_init;
  logic [7:0]  irq_req;
  logic [7:0]  irq_ack;
  logic [15:0] vm_fdin;
  logic [7:4]  vm_virq;
  logic        wbi_stb_i;
  logic        wbi_una_i;
  logic        wbi_ack_o;
  logic [15:0] wbi_dat_o;

  always #5 clk = ~clk;

  f11_wbi_irq #(
    .IRQ_LVL (16'h9CB4),
    .IRQ_VEC (128'h5A77_5A66_5A55_5A44_5A33_5A22_5A11_5A00),
    .IRQ_WAIT(W)
  ) dut (
    .vm_clk_p (clk),
    .vm_init  (vm_init),
    .irq_req  (irq_req),
    .irq_ack  (irq_ack),
    .vm_fdin  (vm_fdin),
    .vm_virq  (vm_virq),
    .wbi_stb_i(wbi_stb_i),
    .wbi_una_i(wbi_una_i),
    .wbi_ack_o(wbi_ack_o),
    .wbi_dat_o(wbi_dat_o)
  );

  // Source levels (4..7) and vectors as seen from the board configuration.
  int          lvl_tab [8] = '{4, 5, 7, 6, 4, 7, 5, 6};
  logic [15:0] vec_tab [8] = '{16'h5A00, 16'h5A11, 16'h5A22, 16'h5A33,
                               16'h5A44, 16'h5A55, 16'h5A66, 16'h5A77};

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          exp_ack_cyc = -1;
  logic [15:0] exp_dat = '0;
  logic [7:0]  exp_iack = '0;
  logic [3:0]  exp_virq = '0;
  logic        chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [3:0] levels_of(input logic [7:0] r);
    logic [3:0] v = 4'b0000;
    for (int i = 0; i < 8; i++)
      if (r[i]) v[lvl_tab[i] - 4] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    exp_virq = vm_init ? 4'b0000 : levels_of(irq_req);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("virq", 32'(vm_virq), 32'(exp_virq));
      if (cyc == exp_ack_cyc) begin
        chk("ack", 32'(wbi_ack_o), 32'd1);
        chk("dat", 32'(wbi_dat_o), 32'(exp_dat));
        chk("iack", 32'(irq_ack), 32'(exp_iack));
      end else begin
        chk("noack", 32'(wbi_ack_o), 32'd0);
        chk("dat0", 32'(wbi_dat_o), 32'd0);
        chk("iack0", 32'(irq_ack), 32'd0);
      end
    end
  end

  // mode 0: run to completion; 1: strobe dropped in WAIT; 2: vm_init in WAIT.
  // jitter 1: randomize irq_req/vm_fdin after the strobe edge; 2: withdraw all requests.
  task automatic do_cycle(input logic una, input logic [7:0] req, input logic [15:0] fd,
                          input int mode, input int jitter, input int hold,
                          input logic lit_en, input logic [15:0] lit_dat,
                          input logic [7:0] lit_iack, input logic [3:0] lit_virq);
    logic        has;
    logic [15:0] d;
    logic [7:0]  ia;
    int          best;
    int          sc;
    has = 1'b1;
    d = 16'h0000;
    ia = 8'h00;
    if (una) d = fd;
    else if (req == 8'h00) has = 1'b0;
    else begin
      best = -1;
      for (int i = 0; i < 8; i++) begin
        sc = lvl_tab[i] * 8 + (7 - i);
        if (req[i] && sc > best) begin
          best = sc;
          d = vec_tab[i];
          ia = 8'h01 << i;
        end
      end
    end
    wbi_una_i = una;
    irq_req   = req;
    vm_fdin   = fd;
    wbi_stb_i = 1'b1;
    exp_dat   = d;
    exp_iack  = ia;
    exp_ack_cyc = has ? cyc + 2 + W : -1;
    if (mode == 0) begin
      if (has) begin
        for (int k = 1; k <= 2 + W; k++) begin
          @(negedge clk);
          if (jitter == 1) begin
            irq_req = 8'($urandom);
            vm_fdin = 16'($urandom);
          end else if (jitter == 2) irq_req = 8'h00;
        end
        if (lit_en) begin
          chk("lit_ack", 32'(wbi_ack_o), 32'd1);
          chk("lit_dat", 32'(wbi_dat_o), 32'(lit_dat));
          chk("lit_iack", 32'(irq_ack), 32'(lit_iack));
          chk("lit_virq", 32'(vm_virq), 32'(lit_virq));
        end
      end
      repeat (hold) @(negedge clk);
    end else begin
      repeat ($urandom_range(1, W)) begin
        @(negedge clk);
        if (jitter == 1) irq_req = 8'($urandom);
      end
      exp_ack_cyc = -1;
      if (mode == 2) begin
        vm_init = 1'b1;
        @(negedge clk);
        vm_init = 1'b0;
        if (lit_en) begin
          chk("rst_ack", 32'(wbi_ack_o), 32'd0);
          chk("rst_dat", 32'(wbi_dat_o), 32'd0);
          chk("rst_iack", 32'(irq_ack), 32'd0);
          chk("rst_virq", 32'(vm_virq), 32'd0);
        end
      end
    end
    wbi_stb_i = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      if (jitter == 1) irq_req = 8'($urandom);
    end
  endtask

  initial begin
    vm_init   = 1'b1;
    irq_req   = 8'hFF;
    vm_fdin   = 16'h0000;
    wbi_stb_i = 1'b0;
    wbi_una_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(wbi_ack_o), 32'd0);
    chk("reset_virq", 32'(vm_virq), 32'd0);
    chk("reset_iack", 32'(irq_ack), 32'd0);
    chk_en  = 1'b1;
    vm_init = 1'b0;
    irq_req = 8'h00;
    repeat (2) @(negedge clk);

    do_cycle(1'b0, 8'h24, 16'h0, 0, 0, 2, 1'b1, 16'h5A22, 8'h04, 4'b1000);
    do_cycle(1'b0, 8'h81, 16'h0, 0, 0, 1, 1'b1, 16'h5A77, 8'h80, 4'b0101);
    do_cycle(1'b0, 8'h02, 16'h0, 0, 2, 1, 1'b1, 16'h5A11, 8'h02, 4'b0000);
    do_cycle(1'b1, 8'h00, 16'o173404, 0, 0, 1, 1'b1, 16'o173404, 8'h00, 4'b0000);
    do_cycle(1'b0, 8'h00, 16'h0, 0, 0, 64, 1'b0, 16'h0, 8'h00, 4'b0000);
    do_cycle(1'b0, 8'h08, 16'h0, 0, 0, 0, 1'b1, 16'h5A33, 8'h08, 4'b0100);
    do_cycle(1'b0, 8'h10, 16'h0, 2, 0, 0, 1'b1, 16'h0, 8'h00, 4'b0000);
    do_cycle(1'b0, 8'h40, 16'h0, 1, 0, 0, 1'b0, 16'h0, 8'h00, 4'b0000);
    do_cycle(1'b0, 8'h40, 16'h0, 0, 0, 0, 1'b1, 16'h5A66, 8'h40, 4'b0010);

    for (int n = 0; n < 250; n++) begin
      int m;
      logic u;
      logic [7:0] r;
      m = $urandom_range(0, 9);
      u = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      do_cycle(u, r, 16'($urandom), (m < 7) ? 0 : (m < 9) ? 1 : 2,
               1, $urandom_range(0, 4), 1'b0, 16'h0, 8'h00, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/f11_wbi_irq.md
# f11_wbi_irq

Interrupt-vector and fast-data responder on the F-11 interrupt Wishbone (`wbi_*`). It is the slave end of the CPU's vector/fast-input interface. It collects eight level-sensitive device requests and drives the CPU's `vm_virq[7:4]` priority lines. On an interrupt-acknowledge cycle it arbitrates the pending sources and returns the vector of the winner. On an unaddressed fast-input cycle it returns the board configuration word.

## Interface

Parameters:

- `IRQ_LVL`, default 16'h0000: 2 bits per source `i` at `[2i+1:2i]`; the source's priority level is 4 + value (level 4..7).
- `IRQ_VEC`, default 128'h0: 16 bits per source `i` at `[16i+15:16i]`; the vector word returned on acknowledge.
- `IRQ_WAIT`, default 0: wait states inserted before ack; range 0..15.

Ports:

- `vm_clk_p` in 1: single clock, rising edge.
- `vm_init` in 1: **reset, synchronous, active-high.**
- `irq_req` in 8: per-source level interrupt requests.
- `irq_ack` out 8: one-cycle pulse to the source whose vector was delivered.
- `vm_fdin` in 16: fast-input configuration word.
- `vm_virq` out 4 [7:4]: registered priority-level requests to the CPU.
- `wbi_stb_i` in 1: cycle strobe.
- `wbi_una_i` in 1: 1 = unaddressed fast-input read; 0 = vector read (IACK).
- `wbi_ack_o` out 1: cycle acknowledge.
- `wbi_dat_o` out 16: returned data.

## Operation

Level outputs:

- Each cycle, `vm_virq[L]` is registered as the OR of `irq_req[i]` over all sources with level L.

State machine:

- IDLE, on `wbi_stb_i`:
  - If `wbi_una_i`: latch `vm_fdin` into the data register, go to WAIT.
  - Else if any `irq_req` is set: go to WAIT.
    - Select the highest level; among equal levels, the lowest index wins.
    - Latch the winner's vector and index.
  - Else (empty IACK): go to HOLD. No ack is issued; the CPU bus timer aborts the cycle.
- WAIT: count down from `IRQ_WAIT`; at 0, go to ACK. With `IRQ_WAIT`=0, WAIT lasts zero cycles, so IDLE moves directly to ACK.
- ACK: one cycle.
  - `wbi_ack_o`=1, `wbi_dat_o` = latched word.
  - For a vector cycle, `irq_ack[sel]`=1.
  - Next state: HOLD.
- HOLD: stay while `wbi_stb_i`=1; return to IDLE when it is 0.

Behaviour rules:

- Arbitration result and data are frozen once latched. A source withdrawing its request during WAIT still receives its ack pulse and has its vector delivered.
- A new request arriving mid-cycle does not preempt the latched source.
- `wbi_stb_i` dropping during WAIT (CPU abort/reset): go to IDLE immediately. No ack and no `irq_ack` are issued.
- `wbi_dat_o` = 0 whenever `wbi_ack_o`=0.
- `vm_fdin` is sampled at cycle start and is not tracked afterwards.

## Timing

- Reset state (`vm_init`=1 at an edge): state IDLE; `wbi_ack_o`=0, `wbi_dat_o`=0, `irq_ack`=0, `vm_virq`=0, wait counter=0.
- `vm_init` overrides a cycle in progress; no ack is issued afterwards.
- `vm_virq` latency: 1 clock from `irq_req`.
- Ack latency: strobe sampled in IDLE at edge T, then `wbi_ack_o` is high during the cycle after edge T+1+`IRQ_WAIT`.
- `wbi_ack_o` is exactly one cycle wide per strobe. No second ack is issued while the strobe stays high.
- The next cycle is accepted no earlier than 1 clock after `wbi_stb_i` is seen low in HOLD.

## Test plan

- Reset: `vm_init` pulsed mid-WAIT (`IRQ_WAIT`=3) -> ack never asserts; all outputs 0 the cycle after reset.
- Priority: `IRQ_LVL` gives src2 = level 7 and src5 = level 7; `irq_req`=8'h24, IACK cycle -> vector of src2 returned, `irq_ack`=8'h04, `vm_virq`=4'b1000.
- Level ordering: src0 at level 4 and src7 at level 6 both requesting -> src7's vector returned; `vm_virq`=4'b0101.
- Wait states and withdrawal: `IRQ_WAIT`=3, src1 drops its request during WAIT -> ack in the 5th cycle after strobe, src1's vector on `wbi_dat_o`, `irq_ack[1]` pulse.
- Fast input: `wbi_una_i`=1, `vm_fdin`=16'o173404 -> ack with 16'o173404, `irq_ack`=0.
- Empty IACK: strobe with `irq_req`=0 held 64 cycles -> no ack. Strobe drops -> IDLE; the next IACK with src3 requesting is served normally.
